// File: rtl/puf_challenge_sequencer_pkg.sv
// Shared types and helpers for the PUF challenge/response sequencer.
// Optional feature macro: PUF_MAJORITY_VOTE_EN (majority-of-3 response sampling).
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        RESET,
        SETTLE,
        SAMPLE,
        DONE
    } puf_state_e;

    localparam int PUF_SEL_W = 2;
    localparam int PUF_LEN_W = 2;
    localparam int VOTE_N    = 3;

    // Settle time grows geometrically with the PUF length setting.
    function automatic int settle_cycles(input int base, input int length);
        return base << length;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Host request/response channel plus the puf_super macro pins.
// master = host/PUF side, slave = sequencer.
interface puf_challenge_sequencer_if #(
    parameter int CHAL_BITS = 16,
    parameter int RESP_BITS = 16
);
    logic                                 req_valid;
    logic                                 req_ready;
    logic [CHAL_BITS-1:0]                 req_challenge;
    logic [puf_ctrl_pkg::PUF_SEL_W-1:0]   req_puf_sel;
    logic [puf_ctrl_pkg::PUF_LEN_W-1:0]   req_length;
    logic                                 abort;
    logic                                 rsp_valid;
    logic                                 rsp_ready;
    logic [RESP_BITS-1:0]                 rsp_data;
    logic                                 busy;
    logic [puf_ctrl_pkg::PUF_SEL_W-1:0]   puf_sel;
    logic [puf_ctrl_pkg::PUF_LEN_W-1:0]   puf_length;
    logic                                 puf_si;
    logic                                 puf_reset;
    logic                                 puf_out;

    modport master (
        output req_valid, req_challenge, req_puf_sel, req_length, abort, rsp_ready, puf_out,
        input  req_ready, rsp_valid, rsp_data, busy, puf_sel, puf_length, puf_si, puf_reset
    );

    modport slave (
        input  req_valid, req_challenge, req_puf_sel, req_length, abort, rsp_ready, puf_out,
        output req_ready, rsp_valid, rsp_data, busy, puf_sel, puf_length, puf_si, puf_reset
    );

endinterface

// File: rtl/puf_challenge_sequencer_shreg.sv
// Load/shift register: parallel load has priority over shift; shifts toward
// the MSB with the serial input entering at the LSB. o_q exposes the top
// OUT_W bits so a serialiser can take just the MSB.
module puf_ctrl_shreg #(
    parameter int W     = 16,
    parameter int OUT_W = W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [W-1:0]     i_load_data,
    input  logic             i_shift,
    input  logic             i_sin,
    output logic [OUT_W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Parallel load or one-bit left shift per enabled cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift) begin
            r_q <= {r_q[W-2:0], i_sin};
        end
    end

    assign o_q = r_q[W-1 -: OUT_W];

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sequences one challenge/response transaction against puf_super:
// shift challenge, pulse PUF reset, settle, sample response, hand it back.
// Optional feature macro: PUF_MAJORITY_VOTE_EN (3 samples per response bit).
//
// state  | meaning
// IDLE   | waiting for a request (req_ready unless abort)
// SHIFT  | challenge driven MSB-first on puf_si, one bit per cycle
// RESET  | puf_reset held high
// SETTLE | waiting SETTLE_BASE << length cycles
// SAMPLE | puf_out shifted into the response register
// DONE   | response presented until rsp_ready
module puf_challenge_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int CHAL_BITS    = 16,
    parameter int RESP_BITS    = 16,
    parameter int RESET_CYCLES = 2,
    parameter int SETTLE_BASE  = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    puf_challenge_sequencer_if.slave bus
);

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int SAMPLE_CYCLES = VOTE_N * RESP_BITS;
`else
    localparam int SAMPLE_CYCLES = RESP_BITS;
`endif
    localparam int MAX_PHASE = max_int(max_int(settle_cycles(SETTLE_BASE, 3), CHAL_BITS),
                                       max_int(RESP_BITS, VOTE_N * RESP_BITS));
    localparam int CNT_W     = $clog2(MAX_PHASE) + 1;

    puf_state_e           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [PUF_SEL_W-1:0] r_sel;
    logic [PUF_LEN_W-1:0] r_len;
    logic                 r_puf_reset;
    logic                 r_rsp_valid;
    logic                 r_busy;
    logic                 r_rdy;

    logic                 w_accept;
    logic                 w_cnt_zero;
    logic                 w_chal_shift;
    logic                 w_chal_msb;
    logic                 w_rsp_shift;
    logic                 w_rsp_bit;
    logic [RESP_BITS-1:0] w_rsp_q;
    logic [CNT_W-1:0]     w_settle_ld;

    assign w_accept     = bus.req_valid & bus.req_ready;
    assign w_cnt_zero   = (r_cnt == '0);
    assign w_chal_shift = (r_state == SHIFT);
    assign w_settle_ld  = CNT_W'(settle_cycles(SETTLE_BASE, int'(r_len)) - 1);

    puf_ctrl_shreg #(
        .W     (CHAL_BITS),
        .OUT_W (1)
    ) u_chal_sr (
        .clk         (clk),
        .rstn        (rstn),
        .i_load      (w_accept),
        .i_load_data (bus.req_challenge),
        .i_shift     (w_chal_shift),
        .i_sin       (1'b0),
        .o_q         (w_chal_msb)
    );

    puf_ctrl_shreg #(
        .W     (RESP_BITS),
        .OUT_W (RESP_BITS)
    ) u_resp_sr (
        .clk         (clk),
        .rstn        (rstn),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_shift     (w_rsp_shift),
        .i_sin       (w_rsp_bit),
        .o_q         (w_rsp_q)
    );

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] r_vote_ph;
    logic [1:0] r_vote_s;

    // Collect the first two samples of each triple; the third is voted live.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vote_ph <= '0;
            r_vote_s  <= '0;
        end else if (r_state != SAMPLE) begin
            r_vote_ph <= '0;
        end else if (r_vote_ph == 2'(VOTE_N - 1)) begin
            r_vote_ph <= '0;
        end else begin
            r_vote_ph <= r_vote_ph + 2'd1;
            r_vote_s  <= {r_vote_s[0], bus.puf_out};
        end
    end

    assign w_rsp_shift = (r_state == SAMPLE) && (r_vote_ph == 2'(VOTE_N - 1));
    assign w_rsp_bit   = majority3(r_vote_s[1], r_vote_s[0], bus.puf_out);
`else
    assign w_rsp_shift = (r_state == SAMPLE);
    assign w_rsp_bit   = bus.puf_out;
`endif

    // Transaction FSM; phase timers are down-counters loaded on entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_len       <= '0;
            r_puf_reset <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rdy       <= 1'b0;
        end else if (r_state != IDLE && bus.abort) begin
            // Abort drops everything, including a response waiting in DONE.
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_puf_reset <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rdy       <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rdy <= 1'b1;
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_cnt   <= CNT_W'(CHAL_BITS - 1);
                        r_sel   <= bus.req_puf_sel;
                        r_len   <= bus.req_length;
                        r_busy  <= 1'b1;
                        r_rdy   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_cnt_zero) begin
                        r_state     <= RESET;
                        r_cnt       <= CNT_W'(RESET_CYCLES - 1);
                        r_puf_reset <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESET: begin
                    if (w_cnt_zero) begin
                        r_state     <= SETTLE;
                        r_cnt       <= w_settle_ld;
                        r_puf_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (w_cnt_zero) begin
                        r_state <= SAMPLE;
                        r_cnt   <= CNT_W'(SAMPLE_CYCLES - 1);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (w_cnt_zero) begin
                        r_state     <= DONE;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_rdy       <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_puf_reset <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_rdy       <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_rdy & ~bus.abort;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = w_rsp_q;
    assign bus.busy       = r_busy;
    assign bus.puf_sel    = r_sel;
    assign bus.puf_length = r_len;
    assign bus.puf_si     = (r_state == SHIFT) & w_chal_msb;
    assign bus.puf_reset  = r_puf_reset;

endmodule
